// File: rtl/gate_lane_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gate_lane_arbiter_if : lane sensors, PIN entry and gate status bus |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
interface gate_lane_arbiter_if;
    logic        s01_a;
    logic        s01_b;
    logic [15:0] pin_a;
    logic [15:0] pin_b;
    logic        pin_vld_a;
    logic        pin_vld_b;
    logic [15:0] rghtpss;
    logic        s02;
    logic        exit_strb;
    logic [1:0]  grant;
    logic        gate;
    logic        wrong_pin_alarm;
    logic        lock_alarm;
    logic [3:0]  occupancy;
    logic        full;

    modport master (
        output s01_a, s01_b, pin_a, pin_b, pin_vld_a, pin_vld_b,
               rghtpss, s02, exit_strb,
        input  grant, gate, wrong_pin_alarm, lock_alarm, occupancy, full
    );

    modport slave (
        input  s01_a, s01_b, pin_a, pin_b, pin_vld_a, pin_vld_b,
               rghtpss, s02, exit_strb,
        output grant, gate, wrong_pin_alarm, lock_alarm, occupancy, full
    );
endinterface
`default_nettype wire

// File: rtl/gate_lane_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | gate_lane_arbiter : two-lane PIN-gated parking entry with lockout  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module gate_lane_arbiter #(
    parameter int MAX_TRIES = 3,
    parameter int CAPACITY  = 8
) (
    input  logic                clk,
    input  logic                rst,
    gate_lane_arbiter_if.slave  bus
);
    localparam logic [2:0] C_MAX_TRIES = 3'(MAX_TRIES);
    localparam logic [3:0] C_CAPACITY  = 4'(CAPACITY);
    localparam logic [1:0] C_GRANT_A   = 2'b01;
    localparam logic [1:0] C_GRANT_B   = 2'b10;
    localparam logic       C_PTR_A     = 1'b0;
    localparam logic       C_PTR_B     = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_OPEN   = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        gate_q, gate_d;
    logic        wpa_q, wpa_d;
    logic        lock_q, lock_d;
    logic [2:0]  tries_q, tries_d;
    logic        ptr_q, ptr_d;
    logic [3:0]  occ_q, occ_d;
    logic        full_q, full_d;

    logic        w_sel_vld;
    logic [15:0] w_sel_pin;
    logic        w_sel_s01;
    logic        w_inc;
    logic [2:0]  w_tries_inc;

    // Only the granted lane's sensor and keypad are observed
    always_comb begin
        w_sel_vld = 1'b0;
        w_sel_pin = 16'h0000;
        w_sel_s01 = 1'b0;
        if (grant_q[0]) begin
            w_sel_vld = bus.pin_vld_a;
            w_sel_pin = bus.pin_a;
            w_sel_s01 = bus.s01_a;
        end else if (grant_q[1]) begin
            w_sel_vld = bus.pin_vld_b;
            w_sel_pin = bus.pin_b;
            w_sel_s01 = bus.s01_b;
        end
    end

    assign w_tries_inc = tries_q + 3'd1;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gate_d  = gate_q;
        wpa_d   = 1'b0;
        lock_d  = lock_q;
        tries_d = tries_q;
        ptr_d   = ptr_q;
        w_inc   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!full_q) begin
                    if (bus.s01_a && bus.s01_b) begin
                        grant_d = (ptr_q == C_PTR_B) ? C_GRANT_A : C_GRANT_B;
                        tries_d = 3'd0;
                        state_d = ST_VERIFY;
                    end else if (bus.s01_a) begin
                        grant_d = C_GRANT_A;
                        tries_d = 3'd0;
                        state_d = ST_VERIFY;
                    end else if (bus.s01_b) begin
                        grant_d = C_GRANT_B;
                        tries_d = 3'd0;
                        state_d = ST_VERIFY;
                    end
                end
            end
            ST_VERIFY: begin
                if (w_sel_vld) begin
                    if (w_sel_pin == bus.rghtpss) begin
                        gate_d  = 1'b1;
                        tries_d = 3'd0;
                        state_d = ST_OPEN;
                    end else begin
                        wpa_d   = 1'b1;
                        tries_d = w_tries_inc;
                        if (w_tries_inc >= C_MAX_TRIES) begin
                            lock_d  = 1'b1;
                            state_d = ST_LOCK;
                        end
                    end
                end else if (!w_sel_s01) begin
                    grant_d = 2'b00;
                    tries_d = 3'd0;
                    state_d = ST_IDLE;
                end
            end
            ST_OPEN: begin
                if (bus.s02) begin
                    gate_d  = 1'b0;
                    grant_d = 2'b00;
                    ptr_d   = grant_q[1] ? C_PTR_B : C_PTR_A;
                    w_inc   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                gate_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = 2'b00;
                gate_d  = 1'b0;
            end
        endcase
    end

    // A simultaneous entry and exit cancel out
    always_comb begin
        occ_d = occ_q;
        if (w_inc && !bus.exit_strb) begin
            if (occ_q < C_CAPACITY) occ_d = occ_q + 4'd1;
        end else if (bus.exit_strb && !w_inc) begin
            if (occ_q != 4'd0) occ_d = occ_q - 4'd1;
        end
        full_d = (occ_d == C_CAPACITY);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 2'b00;
            gate_q  <= 1'b0;
            wpa_q   <= 1'b0;
            lock_q  <= 1'b0;
            tries_q <= 3'd0;
            ptr_q   <= C_PTR_B;
            occ_q   <= 4'd0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gate_q  <= gate_d;
            wpa_q   <= wpa_d;
            lock_q  <= lock_d;
            tries_q <= tries_d;
            ptr_q   <= ptr_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
        end
    end

    assign bus.grant           = grant_q;
    assign bus.gate            = gate_q;
    assign bus.wrong_pin_alarm = wpa_q;
    assign bus.lock_alarm      = lock_q;
    assign bus.occupancy       = occ_q;
    assign bus.full            = full_q;
endmodule
`default_nettype wire

// File: tb/tb_gate_lane_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_gate_lane_arbiter : directed vectors, default and CAPACITY=2    |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_gate_lane_arbiter;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    gate_lane_arbiter_if if1();
    gate_lane_arbiter_if if2();

    gate_lane_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    gate_lane_arbiter #(.MAX_TRIES(3), .CAPACITY(2)) u_dut_cap2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        if1.s01_a = 0; if1.s01_b = 0; if1.pin_a = 0; if1.pin_b = 0;
        if1.pin_vld_a = 0; if1.pin_vld_b = 0; if1.s02 = 0; if1.exit_strb = 0;
        if1.rghtpss = 16'h4037;
        if2.s01_a = 0; if2.s01_b = 0; if2.pin_a = 0; if2.pin_b = 0;
        if2.pin_vld_a = 0; if2.pin_vld_b = 0; if2.s02 = 0; if2.exit_strb = 0;
        if2.rghtpss = 16'h4037;
    endtask

    task automatic do_reset();
        clear_inputs();
        @(negedge clk);
        rst = 1;
        #1;
        tick();
        rst = 0;
    endtask

    // One complete lane-A passage on the default DUT
    task automatic pass_a1();
        if1.s01_a = 1; tick();
        if1.pin_a = 16'h4037; if1.pin_vld_a = 1; tick();
        if1.pin_vld_a = 0; if1.s01_a = 0; if1.s02 = 1; tick();
        if1.s02 = 0;
    endtask

    task automatic pass_a2();
        if2.pin_a = 16'h4037; if2.pin_vld_a = 1; tick();
        if2.pin_vld_a = 0; if2.s02 = 1; tick();
        if2.s02 = 0;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1;
        clear_inputs();
        #12;
        check("rst_grant", 32'(if1.grant), 32'h0);
        check("rst_gate", 32'(if1.gate), 32'h0);
        check("rst_occ", 32'(if1.occupancy), 32'h0);
        check("rst_lock", 32'(if1.lock_alarm), 32'h0);
        tick();
        rst = 0;

        // exit on empty lot saturates at zero
        if1.exit_strb = 1; tick(); if1.exit_strb = 0;
        check("exit_sat0", 32'(if1.occupancy), 32'h0);

        // basic passage on lane A
        if1.s01_a = 1; tick();
        check("a_grant", 32'(if1.grant), 32'h1);
        check("a_gate_pre", 32'(if1.gate), 32'h0);
        if1.pin_a = 16'h4037; if1.pin_vld_a = 1; tick();
        check("a_gate_open", 32'(if1.gate), 32'h1);
        if1.pin_vld_a = 0; if1.s01_a = 0; tick();
        check("a_gate_hold", 32'(if1.gate), 32'h1);
        if1.s02 = 1; tick(); if1.s02 = 0;
        check("a_gate_close", 32'(if1.gate), 32'h0);
        check("a_grant_rel", 32'(if1.grant), 32'h0);
        check("a_occ", 32'(if1.occupancy), 32'h1);

        // round-robin with both lanes waiting
        do_reset();
        if1.s01_a = 1; if1.s01_b = 1; tick();
        check("rr_first_A", 32'(if1.grant), 32'h1);
        if1.pin_a = 16'h4037; if1.pin_vld_a = 1; tick(); if1.pin_vld_a = 0;
        if1.s02 = 1; tick(); if1.s02 = 0;
        check("rr_occ1", 32'(if1.occupancy), 32'h1);
        tick();
        check("rr_second_B", 32'(if1.grant), 32'h2);
        if1.pin_vld_a = 1;
        if1.pin_a = 16'h4037; tick();
        if1.pin_vld_a = 0;
        check("rr_nongrant_ignored", 32'(if1.gate), 32'h0);
        if1.pin_b = 16'h4037; if1.pin_vld_b = 1; tick(); if1.pin_vld_b = 0;
        check("rr_b_gate", 32'(if1.gate), 32'h1);
        if1.s01_a = 0; if1.s01_b = 0; if1.s02 = 1; tick(); if1.s02 = 0;
        check("rr_occ2", 32'(if1.occupancy), 32'h2);

        // one wrong PIN, then the correct one
        do_reset();
        if1.s01_a = 1; tick();
        if1.pin_a = 16'h4031; if1.pin_vld_a = 1; tick(); if1.pin_vld_a = 0;
        check("wp_alarm", 32'(if1.wrong_pin_alarm), 32'h1);
        tick();
        check("wp_alarm_1cyc", 32'(if1.wrong_pin_alarm), 32'h0);
        if1.pin_a = 16'h4037; if1.pin_vld_a = 1; tick(); if1.pin_vld_a = 0;
        check("wp_then_open", 32'(if1.gate), 32'h1);
        check("wp_no_lock", 32'(if1.lock_alarm), 32'h0);

        // abandoning the lane clears the try counter
        do_reset();
        if1.s01_a = 1; tick();
        if1.pin_a = 16'h1111;
        repeat (2) begin
            if1.pin_vld_a = 1; tick(); if1.pin_vld_a = 0;
        end
        if1.s01_a = 0; tick();
        check("abandon_grant", 32'(if1.grant), 32'h0);
        if1.s01_a = 1; tick();
        if1.pin_vld_a = 1; tick(); if1.pin_vld_a = 0;
        check("abandon_tries_clr", 32'(if1.lock_alarm), 32'h0);

        // three wrong PINs lock the gate
        do_reset();
        if1.s01_a = 1; tick();
        if1.pin_a = 16'h4027;
        for (int i = 0; i < 3; i++) begin
            if1.pin_vld_a = 1; tick(); if1.pin_vld_a = 0;
            check("lk_alarm", 32'(if1.wrong_pin_alarm), 32'h1);
            check("lk_lock", 32'(if1.lock_alarm), (i == 2) ? 32'h1 : 32'h0);
            tick();
            check("lk_alarm_low", 32'(if1.wrong_pin_alarm), 32'h0);
        end
        if1.s01_a = 0; if1.s01_b = 1; if1.s02 = 1;
        if1.pin_a = 16'h4037; if1.pin_vld_a = 1;
        tick(); tick();
        if1.pin_vld_a = 0; if1.s02 = 0;
        check("lk_grant_kept", 32'(if1.grant), 32'h1);
        check("lk_gate", 32'(if1.gate), 32'h0);
        check("lk_occ", 32'(if1.occupancy), 32'h0);
        @(negedge clk); rst = 1; #1;
        check("lk_rst_lock", 32'(if1.lock_alarm), 32'h0);
        check("lk_rst_grant", 32'(if1.grant), 32'h0);
        tick(); rst = 0;

        // CAPACITY=2 instance fills up
        do_reset();
        if2.s01_a = 1; tick();
        pass_a2();
        check("c2_occ1", 32'(if2.occupancy), 32'h1);
        tick();
        check("c2_regrant", 32'(if2.grant), 32'h1);
        pass_a2();
        check("c2_occ2", 32'(if2.occupancy), 32'h2);
        check("c2_full", 32'(if2.full), 32'h1);
        tick();
        check("c2_full_nogrant", 32'(if2.grant), 32'h0);
        if2.exit_strb = 1; tick(); if2.exit_strb = 0;
        check("c2_exit_occ", 32'(if2.occupancy), 32'h1);
        check("c2_exit_full", 32'(if2.full), 32'h0);
        tick();
        check("c2_grant_after_exit", 32'(if2.grant), 32'h1);
        if2.s01_a = 0;

        // simultaneous entry and exit, then reset mid-OPEN
        do_reset();
        pass_a1();
        check("sim_occ1", 32'(if1.occupancy), 32'h1);
        if1.s01_a = 1; tick();
        if1.pin_vld_a = 1; tick(); if1.pin_vld_a = 0;
        if1.s02 = 1; if1.exit_strb = 1; tick();
        if1.s02 = 0; if1.exit_strb = 0;
        check("sim_occ_same", 32'(if1.occupancy), 32'h1);
        check("sim_gate", 32'(if1.gate), 32'h0);
        tick();
        if1.pin_vld_a = 1; tick(); if1.pin_vld_a = 0;
        check("mid_open_gate", 32'(if1.gate), 32'h1);
        #3 rst = 1; #1;
        check("async_rst_gate", 32'(if1.gate), 32'h0);
        check("async_rst_occ", 32'(if1.occupancy), 32'h0);
        tick(); rst = 0; if1.s01_a = 1;
        tick();
        check("post_rst_grant", 32'(if1.grant), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
